// File: rtl/safety_island_timer_array.sv
`default_nettype none
// ============================================================================
// Module      : safety_island_timer_array
// Description : Multi-channel timer unit on the core-local register bus.
//               Each channel has an up-counter with an 8-bit prescaler,
//               compare match, optional auto-reload and overflow detection.
//               Every channel drives two level interrupts that mirror its
//               pending bits.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NumTimers    number of timer channels (1..16)
//   CntWidth     counter / compare width in bits (8..32)
//   AddrWidth    decoded register-bus byte-address width
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   reg_valid_i  access request
//   reg_write_i  1 = write, 0 = read
//   reg_addr_i   byte address: [AddrWidth-1:4] channel, [3:2] register
//   reg_wdata_i  write data
//   reg_rdata_o  read data, combinational in the request cycle
//   reg_ready_o  always 1, every access completes in one cycle
//   reg_error_o  request addressed a channel that does not exist
//   irq_o        {ovf_k, cmp_k} per channel k, level, equal to pending bits
// Register map per channel (channel base = 0x10 * k)
//   0x0 CTRL   [0] EN, [1] AUTORELOAD, [15:8] PRESC
//   0x4 COUNT  counter value
//   0x8 CMP    compare value
//   0xC STATUS [0] CMP_PEND, [1] OVF_PEND (write-1-to-clear)
// ============================================================================
module safety_island_timer_array #(
    parameter int NumTimers = 2,
    parameter int CntWidth  = 32,
    parameter int AddrWidth = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   reg_valid_i,
    input  logic                   reg_write_i,
    input  logic [AddrWidth-1:0]   reg_addr_i,
    input  logic [31:0]            reg_wdata_i,
    output logic [31:0]            reg_rdata_o,
    output logic                   reg_ready_o,
    output logic                   reg_error_o,
    output logic [2*NumTimers-1:0] irq_o
);

    localparam int                  c_chan_w     = AddrWidth - 4;
    localparam logic [31:0]         c_num_timers = NumTimers;
    localparam logic [1:0]          c_reg_ctrl   = 2'd0;
    localparam logic [1:0]          c_reg_count  = 2'd1;
    localparam logic [1:0]          c_reg_cmp    = 2'd2;
    localparam logic [CntWidth-1:0] c_cnt_one    = {{(CntWidth-1){1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0] c_cnt_ones   = '1;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [c_chan_w-1:0]            w_chan;
    logic [31:0]                    w_chan_ext;
    logic [1:0]                     w_reg_idx;
    logic                           w_chan_ok;
    logic                           w_wr_en;
    logic [NumTimers-1:0][31:0]     w_rd_data;
    logic                           w_unused_bits;

    assign w_chan     = reg_addr_i[AddrWidth-1:4];
    assign w_chan_ext = 32'(w_chan);
    assign w_reg_idx  = reg_addr_i[3:2];
    // Full-width compare so that out-of-range channels never alias onto
    // an existing one.
    assign w_chan_ok  = (w_chan_ext < c_num_timers);
    assign w_wr_en    = reg_valid_i & reg_write_i & w_chan_ok;

    assign reg_ready_o = 1'b1;
    assign reg_error_o = reg_valid_i & ~w_chan_ok;

    // Byte-lane bits of the address and write-data bits above the
    // implemented fields carry no information.
    assign w_unused_bits = ^{reg_addr_i[1:0], reg_wdata_i};

    // ------------------------------------------------------------------
    // Timer channels
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NumTimers; k++) begin : g_ch
        localparam logic [31:0] c_ch_idx = k;

        logic                w_sel;
        logic                w_wr_ctrl;
        logic                w_wr_count;
        logic                w_wr_cmp;
        logic                w_wr_status;
        logic                w_tick;
        logic                w_match;
        logic                w_all_ones;
        logic                w_set_cmp;
        logic                w_set_ovf;
        logic                w_clr_cmp;
        logic                w_clr_ovf;
        logic [7:0]          w_pre_nxt;
        logic [CntWidth-1:0] w_count_nxt;
        logic [31:0]         w_rd;

        logic                r_en;
        logic                r_autoreload;
        logic [7:0]          r_presc;
        logic [7:0]          r_pre;
        logic [CntWidth-1:0] r_count;
        logic [CntWidth-1:0] r_cmp;
        logic                r_cmp_pend;
        logic                r_ovf_pend;

        assign w_sel       = w_wr_en && (w_chan_ext == c_ch_idx);
        assign w_wr_ctrl   = w_sel && (w_reg_idx == c_reg_ctrl);
        assign w_wr_count  = w_sel && (w_reg_idx == c_reg_count);
        assign w_wr_cmp    = w_sel && (w_reg_idx == c_reg_cmp);
        assign w_wr_status = w_sel && (w_reg_idx == 2'd3);
        assign w_clr_cmp   = w_wr_status & reg_wdata_i[0];
        assign w_clr_ovf   = w_wr_status & reg_wdata_i[1];

        // A tick is the cycle in which the prescaler has reached PRESC.
        assign w_tick     = r_en && (r_pre == r_presc);
        assign w_match    = (r_count == r_cmp);
        assign w_all_ones = (r_count == c_cnt_ones);

        // Prescaler: a CTRL write restarts the division from zero.
        always_comb begin
            if (w_wr_ctrl || !r_en || w_tick) begin
                w_pre_nxt = 8'd0;
            end else begin
                w_pre_nxt = r_pre + 8'd1;
            end
        end

        // Counter update. The compare decision always uses the values
        // held before this edge; a software COUNT write overrides the
        // counter result but the pending events of the tick survive.
        always_comb begin
            w_count_nxt = r_count;
            w_set_cmp   = 1'b0;
            w_set_ovf   = 1'b0;
            if (w_tick) begin
                if (w_match && r_autoreload) begin
                    w_count_nxt = '0;
                    w_set_cmp   = 1'b1;
                end else if (w_match) begin
                    w_count_nxt = r_count + c_cnt_one;
                    w_set_cmp   = 1'b1;
                    w_set_ovf   = w_all_ones;
                end else if (w_all_ones) begin
                    w_count_nxt = '0;
                    w_set_ovf   = 1'b1;
                end else begin
                    w_count_nxt = r_count + c_cnt_one;
                end
            end
            if (w_wr_count) begin
                w_count_nxt = reg_wdata_i[CntWidth-1:0];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_en         <= 1'b0;
                r_autoreload <= 1'b0;
                r_presc      <= 8'd0;
                r_pre        <= 8'd0;
                r_count      <= '0;
                r_cmp        <= '0;
                r_cmp_pend   <= 1'b0;
                r_ovf_pend   <= 1'b0;
            end else begin
                r_pre   <= w_pre_nxt;
                r_count <= w_count_nxt;
                if (w_wr_ctrl) begin
                    r_en         <= reg_wdata_i[0];
                    r_autoreload <= reg_wdata_i[1];
                    r_presc      <= reg_wdata_i[15:8];
                end
                if (w_wr_cmp) begin
                    r_cmp <= reg_wdata_i[CntWidth-1:0];
                end
                // Set has priority over a simultaneous write-1-to-clear.
                r_cmp_pend <= w_set_cmp | (r_cmp_pend & ~w_clr_cmp);
                r_ovf_pend <= w_set_ovf | (r_ovf_pend & ~w_clr_ovf);
            end
        end

        // Register read view; unimplemented bits read as zero.
        always_comb begin
            w_rd = 32'd0;
            case (w_reg_idx)
                c_reg_ctrl: begin
                    w_rd[0]    = r_en;
                    w_rd[1]    = r_autoreload;
                    w_rd[15:8] = r_presc;
                end
                c_reg_count: w_rd[CntWidth-1:0] = r_count;
                c_reg_cmp:   w_rd[CntWidth-1:0] = r_cmp;
                default: begin
                    w_rd[0] = r_cmp_pend;
                    w_rd[1] = r_ovf_pend;
                end
            endcase
        end

        assign w_rd_data[k]  = w_rd;
        assign irq_o[2*k]    = r_cmp_pend;
        assign irq_o[2*k+1]  = r_ovf_pend;
    end

    // ------------------------------------------------------------------
    // Read data return: zero when idle, on writes and on error accesses.
    // ------------------------------------------------------------------
    always_comb begin
        reg_rdata_o = 32'd0;
        if (reg_valid_i && !reg_write_i && w_chan_ok) begin
            for (int k = 0; k < NumTimers; k++) begin
                if (w_chan_ext == 32'(k)) begin
                    reg_rdata_o = w_rd_data[k];
                end
            end
        end
    end

endmodule
`default_nettype wire
